// File: rtl/dsm_ctrl_pkg.sv
// dsm_ctrl_pkg: shared widths, parameter defaults and state encoding for the channel hop controller
package dsm_ctrl_pkg;
  localparam int CH_W = 7;
  localparam int CNT_W = 16;
  localparam int CH_MAX_DEF = 78;
  localparam int RST_CYC_DEF = 4;
  localparam int SETTLE_CYC_DEF = 256;
  typedef enum logic [1:0] {HOLD, SETTLE, IDLE} hop_state_t;
endpackage

// File: rtl/hop_timer.sv
// hop_timer: loadable 16-bit down-counter that stops at zero
module hop_timer
  import dsm_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);
  assign zero = value == '0;
  // load wins over decrement; the count saturates at zero instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= INIT;
    else if (load) value <= load_val;
    else if (dec && !zero) value <= value - 1'b1;
endmodule

// File: rtl/channel_hop_ctrl.sv
// channel_hop_ctrl: channel change sequencer (DSM reset hold, loop settle, idle); optional CH_RANGE_CHECK_EN rejects req_ch > CH_MAX with an err pulse
module channel_hop_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int CH_MAX = CH_MAX_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [CH_W-1:0] req_ch,
  output logic            req_ready,
  output logic [CH_W-1:0] ch_out,
  output logic            dsm_reset_n,
  output logic            settled,
  output logic            err
);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  hop_state_t state;
  logic hs, bad, accept, hold_done, settle_done, load, zero;
  logic [CNT_W-1:0] load_val, value;
  assign req_ready = state != HOLD;
  assign hs = req_valid && req_ready;
`ifdef CH_RANGE_CHECK_EN
  assign bad = hs && (int'(req_ch) > CH_MAX);
  // a rejected request is consumed and flagged for exactly one cycle
  always_ff @(posedge Clk or negedge reset)
    if (!reset) err <= 1'b0;
    else err <= bad;
`else
  assign bad = hs && (CH_MAX < 0);
  assign err = 1'b0;
`endif
  assign accept = hs && !bad;
  assign hold_done = state == HOLD && zero;
  assign settle_done = state == SETTLE && zero;
  assign load = accept || hold_done || settle_done;
  assign load_val = accept ? RST_LD : hold_done ? SETTLE_LD : '0;
  hop_timer #(.INIT(RST_LD)) u_timer (
    .clk(Clk),
    .rst_n(reset),
    .load(load),
    .dec(!load),
    .load_val(load_val),
    .value(value),
    .zero(zero)
  );
  // sequencer: acceptance (also preempting a settle) restarts HOLD, then SETTLE, then IDLE
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      state <= HOLD;
      ch_out <= '0;
      dsm_reset_n <= 1'b0;
      settled <= 1'b0;
    end else if (accept) begin
      state <= HOLD;
      ch_out <= req_ch;
      dsm_reset_n <= 1'b0;
      settled <= 1'b0;
    end else if (hold_done) begin
      state <= SETTLE;
      dsm_reset_n <= 1'b1;
    end else if (settle_done) begin
      state <= IDLE;
      settled <= 1'b1;
    end
endmodule

// File: doc/channel_hop_ctrl.md
CHANNEL_HOP_CTRL -- requirements
Module: channel_hop_ctrl

Interface
REQ-001 SHALL have parameter CH_MAX, default 78, highest legal channel number.
REQ-002 SHALL have parameter RST_CYC, default 4, DSM reset hold length in cycles (legal range 1..255).
REQ-003 SHALL have parameter SETTLE_CYC, default 256, loop settle wait in cycles (legal range 1..65535).
REQ-004 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  channel-change request valid.
REQ-007 SHALL have port req_ch  input  7  requested channel number.
REQ-008 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-009 SHALL have port ch_out  output  7  channel number driven to the mapper/DSM channel input.
REQ-010 SHALL have port dsm_reset_n  output  1  active-low reset to the DSM accumulators.
REQ-011 SHALL have port settled  output  1  high when the current ch_out has completed settling.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-013 SHALL implement states HOLD (DSM in reset), SETTLE (waiting) and IDLE (settled).
REQ-014 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
- req_ready = 1 in IDLE and in SETTLE.
- req_ready = 0 in HOLD.
REQ-015 On acceptance at edge k, SHALL perform all of the following:
- ch_out <= req_ch;
- dsm_reset_n <= 0;
- settled <= 0;
- enter HOLD with the counter loaded to RST_CYC-1.
REQ-016 SHALL leave HOLD after exactly RST_CYC cycles: dsm_reset_n <= 1 and enter SETTLE with the counter loaded to SETTLE_CYC-1.
REQ-017 SHALL leave SETTLE after exactly SETTLE_CYC cycles: settled <= 1 and enter IDLE.
- Total latency: settled rises at edge k+RST_CYC+SETTLE_CYC.
REQ-018 SHALL treat a request accepted in SETTLE as preemption: abandon the current settle and perform REQ-015 with the new channel.
REQ-019 SHALL hold ch_out constant in every state except the acceptance edge.
REQ-020 SHALL re-run the full HOLD/SETTLE sequence for a request equal to the current ch_out; no shortcut is taken.
REQ-021 SHALL use a 16-bit down-counter that never wraps: it is reloaded on every state entry and not decremented below 0.
REQ-022 SHALL keep err at 0 except as defined in REQ-026.

Reset
REQ-023 While reset = 0, SHALL force ch_out = 0, dsm_reset_n = 0, settled = 0, err = 0, state = HOLD, counter = RST_CYC-1.
REQ-024 After reset releases, SHALL run HOLD then SETTLE for channel 0 exactly as if channel 0 had been accepted on the release edge.
- req_ready = 0 until SETTLE is reached.
REQ-025 SHALL abort any sequence in progress when reset asserts mid-operation; no partial state is retained.

Configuration
REQ-026 With macro CH_RANGE_CHECK_EN defined, a handshake with req_ch > CH_MAX SHALL complete (consumed) and pulse err for one cycle.
- State, ch_out, dsm_reset_n and settled remain unchanged.
- An ongoing SETTLE continues.
REQ-027 Without CH_RANGE_CHECK_EN, every req_ch value SHALL be accepted per REQ-015 and err SHALL be tied to 0.

Structure
REQ-028 SHALL take the state enum, CH_W = 7 and the parameter defaults from shared package dsm_ctrl_pkg.
REQ-029 SHALL implement the loadable down-counter as sub-module hop_timer: load, value, decrement, zero flag.

Verification (RST_CYC=4, SETTLE_CYC=16, CH_MAX=78)
REQ-030 Power-up: release reset at edge 0 -> dsm_reset_n = 0 for edges 0..3, rises at edge 4; settled rises at edge 20; ch_out = 0 throughout.
REQ-031 Hop: in IDLE, req_ch=37 accepted at edge k -> ch_out = 37 at k, dsm_reset_n low k..k+3, settled = 1 at k+20.
REQ-032 Preempt: req 10 at k, then req 55 at k+8 (in SETTLE) -> ch_out = 55 at k+8, dsm_reset_n low again, settled at k+28 only.
REQ-033 Back-pressure: req_valid held during HOLD -> req_ready = 0 and no acceptance until the first SETTLE cycle.
REQ-034 Range (CH_RANGE_CHECK_EN): req_ch=100 in IDLE -> err = 1 for one cycle, ch_out and settled unchanged; without the macro -> ch_out = 100 and a full sequence runs.
REQ-035 Mid-reset: assert reset at k+2 of a hop -> all outputs at reset values, then REQ-030 timing for channel 0.
